// File: rtl/mac_tile_core_pkg.sv
// Shared types for the weight-stationary MAC tile: instruction field layout.
package mac_tile_core_pkg;

    localparam int unsigned INST_W = 2;

    // Bit 1 = execute, bit 0 = kernel load, matching the inst_w/inst_e wire order.
    typedef struct packed {
        logic execute;
        logic kernel_load;
    } inst_t;

    localparam inst_t INST_IDLE = '0;

endpackage

// File: rtl/mac_tile_core_mul_add.sv
// Combinational signed multiply-accumulate: y = sext(a) * sext(b) + c, wrapping.
module mac_mul_add #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic signed [bw-1:0]      a,
    input  logic signed [bw-1:0]      b,
    input  logic signed [psum_bw-1:0] c,
    output logic signed [psum_bw-1:0] y
);

    logic signed [2*bw-1:0]    a_ext;
    logic signed [2*bw-1:0]    b_ext;
    logic signed [2*bw-1:0]    prod;
    logic signed [psum_bw-1:0] prod_ext;

    always_comb begin
        a_ext    = (2*bw)'(a);
        b_ext    = (2*bw)'(b);
        prod     = a_ext * b_ext;
        prod_ext = (psum_bw)'(prod);
        y        = prod_ext + c;
    end

endmodule

// File: rtl/mac_tile_core.sv
// Systolic MAC tile: holds one weight, computes act*weight + north psum, forwards east.
module mac_tile_core
    import mac_tile_core_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [bw-1:0]       in_w,
    input  logic [INST_W-1:0]   inst_w,
    input  logic [psum_bw-1:0]  in_n,
    output logic [bw-1:0]       out_e,
    output logic [INST_W-1:0]   inst_e,
    output logic [psum_bw-1:0]  out_s
);

    inst_t              inst_in;
    logic [bw-1:0]      a_q, a_d;
    logic [bw-1:0]      b_q, b_d;
    logic [psum_bw-1:0] c_q, c_d;
    inst_t              inst_q, inst_d;
    logic               load_ready_q, load_ready_d;
    logic               load_take;

    always_comb begin
        inst_in      = inst_t'(inst_w);
        load_take    = inst_in.kernel_load & load_ready_q;

        a_d          = a_q;
        b_d          = b_q;
        c_d          = in_n;
        load_ready_d = load_ready_q & ~inst_in.kernel_load;

        if (inst_in != INST_IDLE) a_d = in_w;
        if (load_take)            b_d = in_w;

        // The first kernel load is consumed here; only later loads travel east.
        inst_d.execute     = inst_in.execute;
        inst_d.kernel_load = inst_in.kernel_load & ~load_ready_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            inst_q       <= INST_IDLE;
            load_ready_q <= 1'b1;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            inst_q       <= inst_d;
            load_ready_q <= load_ready_d;
        end
    end

    mac_mul_add #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a (a_q),
        .b (b_q),
        .c (c_q),
        .y (out_s)
    );

    assign out_e  = a_q;
    assign inst_e = inst_q;

endmodule

// File: tb/tb_mac_tile_core.sv
// Directed-vector bench for mac_tile_core with hand-computed expected values.
module tb_mac_tile_core;

    localparam int bw      = 4;
    localparam int psum_bw = 16;

    logic               clk;
    logic               reset;
    logic [bw-1:0]      in_w;
    logic [1:0]         inst_w;
    logic [psum_bw-1:0] in_n;
    logic [bw-1:0]      out_e;
    logic [1:0]         inst_e;
    logic [psum_bw-1:0] out_s;

    int unsigned n_checks;
    int unsigned n_fail;

    mac_tile_core #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_w   (in_w),
        .inst_w (inst_w),
        .in_n   (in_n),
        .out_e  (out_e),
        .inst_e (inst_e),
        .out_s  (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [1:0] inst, input logic [bw-1:0] w, input logic [psum_bw-1:0] n);
        inst_w = inst;
        in_w   = w;
        in_n   = n;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'b00, '0, '0);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        inst_w   = 2'b00;
        in_w     = '0;
        in_n     = '0;
        #2;

        // Reset state
        do_reset();
        check("rst_out_s",  32'(out_s),  32'h0000);
        check("rst_out_e",  32'(out_e),  32'h0);
        check("rst_inst_e", 32'(inst_e), 32'h0);

        // Load -3, execute 5 with psum 10 -> -5
        step(2'b01, 4'hD, 16'h0000);
        check("load_inst_e", 32'(inst_e), 32'h0);
        check("load_out_e",  32'(out_e),  32'hD);
        step(2'b10, 4'h5, 16'h000A);
        check("exec_out_s",  32'(out_s),  32'hFFFB);
        check("exec_out_e",  32'(out_e),  32'h5);
        check("exec_inst_e", 32'(inst_e), 32'h2);
        step(2'b00, 4'h0, 16'h000A);
        check("idle_out_s",  32'(out_s),  32'hFFFB);
        check("idle_out_e",  32'(out_e),  32'h5);
        check("idle_inst_e", 32'(inst_e), 32'h0);

        // Second load passes east, weight stays -3: 2*-3 = -6
        step(2'b01, 4'h2, 16'h0000);
        check("load2_inst_e", 32'(inst_e), 32'h1);
        check("load2_out_e",  32'(out_e),  32'h2);
        check("load2_out_s",  32'(out_s),  32'hFFFA);

        // Extremes: -8 * -8 = 64
        do_reset();
        step(2'b01, 4'h8, 16'h0000);
        step(2'b10, 4'h8, 16'h0000);
        check("neg8_out_s", 32'(out_s), 32'h0040);

        // 7*7 + 0x7FFF wraps
        do_reset();
        step(2'b01, 4'h7, 16'h0000);
        step(2'b10, 4'h7, 16'h7FFF);
        check("wrap_out_s", 32'(out_s), 32'h8030);

        // Activation stream 1,2,3 with weight 3
        do_reset();
        step(2'b01, 4'h3, 16'h0000);
        step(2'b10, 4'h1, 16'h0000);
        check("strm1_out_s",  32'(out_s),  32'h0003);
        check("strm1_inst_e", 32'(inst_e), 32'h2);
        step(2'b10, 4'h2, 16'h0000);
        check("strm2_out_s",  32'(out_s),  32'h0006);
        check("strm2_inst_e", 32'(inst_e), 32'h2);
        step(2'b10, 4'h3, 16'h0000);
        check("strm3_out_s",  32'(out_s),  32'h0009);
        check("strm3_inst_e", 32'(inst_e), 32'h2);

        // Reset mid-stream clears everything
        reset = 1'b1;
        step(2'b10, 4'h4, 16'h1234);
        reset = 1'b0;
        check("mid_rst_out_s",  32'(out_s),  32'h0000);
        check("mid_rst_out_e",  32'(out_e),  32'h0);
        check("mid_rst_inst_e", 32'(inst_e), 32'h0);

        // Load accepted again after reset: weight 2, act 4, psum 5 -> 13
        step(2'b01, 4'h2, 16'h0000);
        check("reload_inst_e", 32'(inst_e), 32'h0);
        check("reload_out_e",  32'(out_e),  32'h2);
        step(2'b10, 4'h4, 16'h0005);
        check("reload_out_s", 32'(out_s), 32'h000D);

        // inst 11 on fresh tile: weight and activation both -2 -> 4
        do_reset();
        step(2'b11, 4'hE, 16'h0000);
        check("both_out_s",  32'(out_s),  32'h0004);
        check("both_out_e",  32'(out_e),  32'hE);
        check("both_inst_e", 32'(inst_e), 32'h2);
        // Weight now fixed: another 11 forwards load, weight stays -2: 1*-2 = -2
        step(2'b11, 4'h1, 16'h0000);
        check("both2_out_s",  32'(out_s),  32'hFFFE);
        check("both2_inst_e", 32'(inst_e), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
